// File: rtl/mul_seq_ctrl.sv
// Control sequencer for the byte-sliced 4-lane RV32M multiplier datapath:
// accept, four rotate-and-accumulate passes, pipeline drain, held result.
module mul_seq_ctrl #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] funct3_i,
  output logic       ready_o,
  input  logic       flush_i,
  output logic       valid_o,
  input  logic       result_ready_i,
  output logic       reg_A_en_o,
  output logic       reg_B_en_o,
  output logic       mux_B_sel_o,
  output logic       rol_en_o,
  output logic       en_pipe_o,
  output logic       AC_en_o,
  output logic       acc_clr_o,
  output logic [1:0] shift_amount_o,
  output logic       signed_A_o,
  output logic       signed_B_o,
  output logic       upper_o
);

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic            upper_q, sA_q, sB_q;
  logic            dec_upper, dec_sA, dec_sB;
  logic            req_ok, accept;

  always_comb begin
    dec_upper = 1'b0;
    dec_sA    = 1'b0;
    dec_sB    = 1'b0;
    case (funct3_i[1:0])
      2'b01:   begin dec_upper = 1'b1; dec_sA = 1'b1; dec_sB = 1'b1; end
      2'b10:   begin dec_upper = 1'b1; dec_sA = 1'b1; end
      2'b11:   dec_upper = 1'b1;
      default: ;
    endcase
  end

  // funct3[2] selects DIV/REM, which this unit never accepts
  assign req_ok = start_i & ~funct3_i[2] & ~flush_i;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    drn_d          = drn_q;
    accept         = 1'b0;
    ready_o        = 1'b0;
    valid_o        = 1'b0;
    reg_A_en_o     = 1'b0;
    reg_B_en_o     = 1'b0;
    mux_B_sel_o    = 1'b0;
    rol_en_o       = 1'b0;
    en_pipe_o      = 1'b0;
    AC_en_o        = 1'b0;
    acc_clr_o      = 1'b0;
    shift_amount_o = 2'b00;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        accept  = req_ok;
      end
      S_MUL: begin
        en_pipe_o      = 1'b1;
        AC_en_o        = 1'b1;
        shift_amount_o = {k_q[1], k_q[1] ^ k_q[0]};
        if (k_q != 2'd3) begin
          reg_B_en_o  = 1'b1;
          mux_B_sel_o = 1'b1;
          rol_en_o    = 1'b1;
          k_d         = k_q + 2'd1;
        end else begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end
      end
      S_DRAIN: begin
        en_pipe_o = 1'b1;
        if (drn_q == DW'(PIPE_DEPTH - 1)) state_d = S_DONE;
        else                              drn_d   = drn_q + 1'b1;
      end
      S_DONE: begin
        valid_o = 1'b1;
        ready_o = result_ready_i;
        if (result_ready_i) begin
          accept  = req_ok;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      reg_A_en_o = 1'b1;
      reg_B_en_o = 1'b1;
      acc_clr_o  = 1'b1;
      state_d    = S_MUL;
      k_d        = 2'd0;
    end
    // flush overrides everything decided above, including a same-cycle accept
    if (flush_i) begin
      reg_A_en_o     = 1'b0;
      reg_B_en_o     = 1'b0;
      mux_B_sel_o    = 1'b0;
      rol_en_o       = 1'b0;
      en_pipe_o      = 1'b0;
      AC_en_o        = 1'b0;
      shift_amount_o = 2'b00;
      acc_clr_o      = 1'b1;
      state_d        = S_IDLE;
      k_d            = 2'd0;
    end
  end

  // Decode is visible in the accept cycle so the datapath can latch it with reg_A_en
  assign upper_o    = accept ? dec_upper : upper_q;
  assign signed_A_o = accept ? dec_sA    : sA_q;
  assign signed_B_o = accept ? dec_sB    : sB_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      drn_q   <= '0;
      upper_q <= 1'b0;
      sA_q    <= 1'b0;
      sB_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drn_q   <= drn_d;
      if (accept) begin
        upper_q <= dec_upper;
        sA_q    <= dec_sA;
        sB_q    <= dec_sB;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench: drives mul_seq_ctrl and a small behavioural byte-sliced datapath
// from its control outputs, checking control patterns and final products.
module tb_mul_seq_ctrl;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic start = 1'b0, flush = 1'b0, rr = 1'b1;
  logic [2:0] f3 = 3'b000;
  logic ready, valid, rega, regb, muxb, rol, enp, acen, clr, sa, sb, up;
  logic [1:0] sh;
  logic [31:0] op_a = '0, op_b = '0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.PIPE_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .funct3_i(f3), .ready_o(ready),
    .flush_i(flush), .valid_o(valid), .result_ready_i(rr), .reg_A_en_o(rega),
    .reg_B_en_o(regb), .mux_B_sel_o(muxb), .rol_en_o(rol), .en_pipe_o(enp),
    .AC_en_o(acen), .acc_clr_o(clr), .shift_amount_o(sh), .signed_A_o(sa),
    .signed_B_o(sb), .upper_o(up)
  );

  // {regA, regB, muxB, rol, en_pipe, AC, clr, shift[1:0], sA, sB, upper}
  logic [11:0] ctl;
  assign ctl = {rega, regb, muxb, rol, enp, acen, clr, sh, sa, sb, up};

  // Behavioural datapath: lane products from rotated B, two pipe stages, 64-bit accumulator
  logic [31:0] ra, rb;
  logic        msa, msb, mup;
  logic [63:0] p0, p1, acc;
  logic        pv0, pv1;
  logic [31:0] res;

  function automatic logic [63:0] term(input logic [31:0] a, input logic [31:0] b,
                                       input logic sga, input logic sgb, input logic [1:0] s);
    int k, pos;
    logic [63:0] ae, be;
    case (s)
      2'b00:   k = 0;
      2'b01:   k = 1;
      2'b11:   k = 2;
      default: k = 3;
    endcase
    pos = (2 * k) % 4;
    ae = sga ? {{32{a[31]}}, a} : {32'h0, a};
    be = {56'h0, b[pos*8 +: 8]};
    if (sgb && k == 3 && b[pos*8+7]) be[63:8] = '1;
    return (ae * be) << (8 * k);
  endfunction

  always @(posedge clk) begin
    if (rega) begin ra <= op_a; msa <= sa; msb <= sb; mup <= up; end
    if (regb) rb <= muxb ? (rol ? {rb[23:0], rb[31:24]} : rb) : op_b;
    if (clr) begin
      acc <= '0; pv0 <= 1'b0; pv1 <= 1'b0;
    end else if (enp) begin
      p0 <= term(ra, rb, msa, msb, sh); pv0 <= acen;
      p1 <= p0;                         pv1 <= pv0;
      if (pv1) acc <= acc + p1;
    end
  end
  assign res = mup ? acc[63:32] : acc[31:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept at cycle 0, wait (bounded) for valid_o, check latency, decode and product
  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] dec, input logic [31:0] exp);
    int n;
    step();
    start = 1'b1; f3 = fn; op_a = a; op_b = b; #1;
    chk({tag, "_accept"}, {20'h0, ctl}, {20'h0, 7'b1100001, 2'b00, dec});
    step();
    start = 1'b0; #1;
    n = 1;
    while (!valid && n < 30) begin step(); #1; n++; end
    chk({tag, "_lat"}, n, 7);
    chk({tag, "_res"}, res, exp);
  endtask

  logic [1:0] gray [4];
  int n;
  logic seen;

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;

    #12;
    chk("rst_ctl",   {20'h0, ctl}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    @(negedge clk); rst_ni = 1'b1;

    // MUL 7 x 0xFFFFFFFD, cycle by cycle
    step();
    start = 1'b1; f3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; #1;
    chk("mul_acc_ctl", {20'h0, ctl}, {20'h0, 12'b1100001_00_000});
    for (int k = 0; k < 4; k++) begin
      step();
      start = 1'b0; #1;
      if (k < 3) chk("mul_step_ctl", {20'h0, ctl}, {20'h0, 7'b0111110, gray[k], 3'b000});
      else       chk("mul_step_ctl", {20'h0, ctl}, {20'h0, 7'b0000110, gray[k], 3'b000});
      chk("mul_step_ready", {31'h0, ready}, 32'h0);
    end
    for (int d = 0; d < 2; d++) begin
      step(); #1;
      chk("drain_ctl",   {20'h0, ctl}, {20'h0, 12'b0000100_00_000});
      chk("drain_valid", {31'h0, valid}, 32'h0);
    end
    step(); #1;
    chk("mul_valid", {31'h0, valid}, 32'h1);
    chk("mul_res",   res, 32'hFFFF_FFEB);
    chk("done_ctl",  {20'h0, ctl}, 32'h0);
    step(); #1;
    chk("idle_ready", {31'h0, ready}, 32'h1);
    chk("idle_valid", {31'h0, valid}, 32'h0);

    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 32'hFFFF_FFFE);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 3'b111, 32'h4000_0000);

    // funct3[2] set: ignored, decode stays at the MULH values
    step();
    start = 1'b1; f3 = 3'b100; op_a = 32'd1; op_b = 32'd1; #1;
    chk("div_ctl",   {20'h0, ctl}, {20'h0, 12'b0000000_00_111});
    chk("div_ready", {31'h0, ready}, 32'h1);
    step();
    start = 1'b0; #1;
    chk("div_idle_ctl",   {20'h0, ctl}, {20'h0, 12'b0000000_00_111});
    chk("div_idle_ready", {31'h0, ready}, 32'h1);

    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'hFFFF_FFFF);

    // Backpressure: MUL 6 x 7 held for 5 cycles, then back-to-back MUL 3 x 5
    step();
    rr = 1'b0;
    run_op("bp", 3'b000, 32'd6, 32'd7, 3'b000, 32'h0000_002A);
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      chk("bp_valid", {31'h0, valid}, 32'h1);
      chk("bp_res",   res, 32'h0000_002A);
      chk("bp_ctl",   {20'h0, ctl}, 32'h0);
      chk("bp_ready", {31'h0, ready}, 32'h0);
    end
    step();
    rr = 1'b1; start = 1'b1; f3 = 3'b000; op_a = 32'd3; op_b = 32'd5; #1;
    chk("b2b_ready", {31'h0, ready}, 32'h1);
    chk("b2b_ctl",   {20'h0, ctl}, {20'h0, 12'b1100001_00_000});
    step();
    start = 1'b0; #1;
    n = 1;
    while (!valid && n < 30) begin step(); #1; n++; end
    chk("b2b_lat", n, 7);
    chk("b2b_res", res, 32'h0000_000F);

    // Flush at cycle 3 of MUL 9 x 9, with a start request that must be ignored
    step();
    start = 1'b1; f3 = 3'b000; op_a = 32'd9; op_b = 32'd9; #1;
    step(); start = 1'b0;
    step();
    step();
    flush = 1'b1; start = 1'b1; #1;
    chk("flush_ctl", {20'h0, ctl}, {20'h0, 12'b0000001_00_000});
    step();
    flush = 1'b0; start = 1'b0; #1;
    chk("flush_ready", {31'h0, ready}, 32'h1);
    chk("flush_ctl2",  {20'h0, ctl}, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin step(); #1; if (valid) seen = 1'b1; end
    chk("flush_novalid", {31'h0, seen}, 32'h0);
    run_op("post_flush", 3'b000, 32'd2, 32'd2, 3'b000, 32'h0000_0004);

    // Async reset pulsed during DRAIN
    step();
    start = 1'b1; f3 = 3'b011; op_a = 32'd1; op_b = 32'd1; #1;
    step(); start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    #1;
    chk("pre_rst_drain", {20'h0, ctl}, {20'h0, 12'b0000100_00_001});
    rst_ni = 1'b0; #1;
    chk("arst_ctl",   {20'h0, ctl}, 32'h0);
    chk("arst_ready", {31'h0, ready}, 32'h1);
    chk("arst_valid", {31'h0, valid}, 32'h0);
    @(negedge clk); rst_ni = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin step(); #1; if (valid || !ready) seen = 1'b1; end
    chk("arst_stays_idle", {31'h0, seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
